// File: rtl/counter_seq_ctrl_if.sv
// rtl/counter_seq_ctrl_if.sv - requester handshake and 74x867 pin bundle for counter_seq_ctrl
// master: the two requesters plus the counter stages; slave: the sequencer.
interface counter_seq_ctrl_if #(
  parameter int LEN_W = 4
);
  logic             reqA;
  logic             reqB;
  logic [1:0]       opA;
  logic [1:0]       opB;
  logic [LEN_W-1:0] lenA;
  logic [LEN_W-1:0] lenB;
  logic             satA;
  logic             satB;
  logic [15:0]      dataA;
  logic [15:0]      dataB;
  logic             ackA;
  logic             ackB;
  logic             tcHit;
  logic             busy;
  logic [1:0]       cntS;
  logic             cntEnpN;
  logic             cntEntN;
  logic [15:0]      cntD;
  logic             cntRcoN;

  modport master (
    output reqA, reqB, opA, opB, lenA, lenB, satA, satB, dataA, dataB, cntRcoN,
    input  ackA, ackB, tcHit, busy, cntS, cntEnpN, cntEntN, cntD
  );

  modport slave (
    input  reqA, reqB, opA, opB, lenA, lenB, satA, satB, dataA, dataB, cntRcoN,
    output ackA, ackB, tcHit, busy, cntS, cntEnpN, cntEntN, cntD
  );
endinterface

// File: rtl/counter_seq_ctrl.sv
// rtl/counter_seq_ctrl.sv - round-robin sequencer sharing a cascaded 74x867 16-bit counter
// Grants one requester at a time and drives clear/load/count bursts on the shared S/enable/data pins.
module counter_seq_ctrl #(
  parameter int LEN_W = 4
) (
  input logic              clk,
  input logic              asyncResetN,
  counter_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_e;

  localparam logic [1:0]       S_HOLD  = 2'b11;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  state_e           state_q;
  logic             count_q;
  logic             sat_q;
  logic [LEN_W-1:0] step_q;
  logic             tc_q;
  logic             gnt_b_q;
  logic             last_b_q;
  logic [1:0]       cnt_s_q;
  logic [15:0]      cnt_d_q;
  logic             ent_n_q;
  logic             enp_r_q;
  logic             ack_a_q;
  logic             ack_b_q;
  logic             tc_hit_q;

  logic             grant_b_d;
  logic [1:0]       sel_op;
  logic [LEN_W-1:0] sel_len;
  logic             sel_sat;
  logic [15:0]      sel_data;
  logic             sel_count;
  logic             rco_hit;
  logic             tc_d;
  logic             run_last;

  // B wins only when A is absent or A was the last one served.
  always_comb begin
    grant_b_d = bus.reqB & (~bus.reqA | ~last_b_q);
    sel_op    = grant_b_d ? bus.opB   : bus.opA;
    sel_len   = grant_b_d ? bus.lenB  : bus.lenA;
    sel_sat   = grant_b_d ? bus.satB  : bus.satA;
    sel_data  = grant_b_d ? bus.dataB : bus.dataA;
    sel_count = sel_op[0];
    rco_hit   = ~bus.cntRcoN;
    tc_d      = tc_q | (count_q & rco_hit);
    run_last  = ~count_q | (sat_q & rco_hit) | (step_q == '0);
  end

  always_ff @(posedge clk or negedge asyncResetN) begin
    if (!asyncResetN) begin
      state_q  <= ST_IDLE;
      count_q  <= 1'b0;
      sat_q    <= 1'b0;
      step_q   <= '0;
      tc_q     <= 1'b0;
      gnt_b_q  <= 1'b0;
      last_b_q <= 1'b1;
      cnt_s_q  <= S_HOLD;
      cnt_d_q  <= 16'h0000;
      ent_n_q  <= 1'b1;
      enp_r_q  <= 1'b1;
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      tc_hit_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.reqA || bus.reqB) begin
            gnt_b_q <= grant_b_d;
            count_q <= sel_count;
            sat_q   <= sel_sat & sel_count;
            step_q  <= sel_count ? sel_len : '0;
            tc_q    <= 1'b0;
            cnt_s_q <= sel_op;
            cnt_d_q <= sel_data;
            ent_n_q <= ~sel_count;
            enp_r_q <= ~sel_count;
            state_q <= ST_RUN;
          end
        end

        ST_RUN: begin
          tc_q <= tc_d;
          if (run_last) begin
            cnt_s_q  <= S_HOLD;
            ent_n_q  <= 1'b1;
            enp_r_q  <= 1'b1;
            ack_a_q  <= ~gnt_b_q;
            ack_b_q  <= gnt_b_q;
            tc_hit_q <= tc_d;
            state_q  <= ST_DONE;
          end else begin
            step_q <= step_q - LEN_ONE;
          end
        end

        ST_DONE: begin
          ack_a_q  <= 1'b0;
          ack_b_q  <= 1'b0;
          tc_hit_q <= 1'b0;
          tc_q     <= 1'b0;
          sat_q    <= 1'b0;
          last_b_q <= gnt_b_q;
          state_q  <= ST_IDLE;
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Saturation gate is combinational: rcoN only depends on registered S/entN.
  assign bus.cntEnpN = enp_r_q | (sat_q & ~bus.cntRcoN);
  assign bus.cntS    = cnt_s_q;
  assign bus.cntEntN = ent_n_q;
  assign bus.cntD    = cnt_d_q;
  assign bus.ackA    = ack_a_q;
  assign bus.ackB    = ack_b_q;
  assign bus.tcHit   = tc_hit_q;
  assign bus.busy    = (state_q != ST_IDLE);

endmodule

// File: tb/tb_counter_seq_ctrl.sv
// tb/tb_counter_seq_ctrl.sv - bench for counter_seq_ctrl with a 16-bit 74x867 cascade model
// Table vectors, round-robin and reset-abort sequences, and random ops against a reference.
module tb_counter_seq_ctrl;
  localparam int LEN_W = 4;

  typedef struct {
    logic        who;
    logic [1:0]  op;
    logic [3:0]  len;
    logic        sat;
    logic [15:0] data;
    logic [15:0] exp_cnt;
    logic        exp_tc;
    int          exp_lat;
  } vec_t;

  logic clk = 1'b0;
  logic asyncResetN;
  always #5 clk = ~clk;

  counter_seq_ctrl_if #(.LEN_W(LEN_W)) bus_if ();
  counter_seq_ctrl #(.LEN_W(LEN_W)) u_dut (
    .clk        (clk),
    .asyncResetN(asyncResetN),
    .bus        (bus_if)
  );

  // Both 8-bit stages collapse to one 16-bit up/down counter with async clear.
  logic [15:0] cnt_model = 16'h0000;
  wire clr_n = (bus_if.cntS != 2'b00);
  always @(posedge clk or negedge clr_n) begin
    if (!clr_n) cnt_model <= 16'h0000;
    else if (bus_if.cntS == 2'b10) cnt_model <= bus_if.cntD;
    else if (!bus_if.cntEnpN && !bus_if.cntEntN) begin
      if (bus_if.cntS == 2'b11) cnt_model <= cnt_model + 16'd1;
      else if (bus_if.cntS == 2'b01) cnt_model <= cnt_model - 16'd1;
    end
  end
  assign bus_if.cntRcoN = ~(~bus_if.cntEntN &&
                            ((bus_if.cntS == 2'b11 && cnt_model == 16'hFFFF) ||
                             (bus_if.cntS == 2'b01 && cnt_model == 16'h0000)));

  int checks = 0;
  int failures = 0;
  int s00_cnt = 0;
  int s10_cnt = 0;
  int cyc = 0;
  always @(negedge clk) begin
    if (bus_if.cntS == 2'b00) s00_cnt++;
    if (bus_if.cntS == 2'b10) s10_cnt++;
  end
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic void ref_model(input logic [1:0] op, input logic [3:0] len, input logic sat,
                                    input logic [15:0] data, input logic [15:0] start,
                                    output logic [15:0] fin, output logic tc, output int lat);
    logic [15:0] v;
    logic [15:0] term;
    tc  = 1'b0;
    lat = 2;
    fin = start;
    if (op == 2'b00) fin = 16'h0000;
    else if (op == 2'b10) fin = data;
    else begin
      v    = start;
      term = (op == 2'b11) ? 16'hFFFF : 16'h0000;
      lat  = int'(len) + 2;
      for (int i = 0; i <= int'(len); i++) begin
        if (v == term) begin
          tc = 1'b1;
          if (sat) begin
            lat = i + 2;
            break;
          end
        end
        v = (op == 2'b11) ? v + 16'd1 : v - 16'd1;
      end
      fin = v;
    end
  endfunction

  task automatic do_op(input logic who, input logic [1:0] op, input logic [3:0] len,
                       input logic sat, input logic [15:0] data,
                       output logic [15:0] cnt, output logic tc, output int lat,
                       output int d00, output int d10, output logic other);
    int s00_0;
    int s10_0;
    logic got;
    s00_0 = s00_cnt;
    s10_0 = s10_cnt;
    @(negedge clk);
    if (who) begin
      bus_if.opB = op; bus_if.lenB = len; bus_if.satB = sat; bus_if.dataB = data; bus_if.reqB = 1'b1;
    end else begin
      bus_if.opA = op; bus_if.lenA = len; bus_if.satA = sat; bus_if.dataA = data; bus_if.reqA = 1'b1;
    end
    lat = 0; got = 1'b0; tc = 1'b0; other = 1'b0;
    while (!got && lat < 40) begin
      @(negedge clk);
      lat++;
      if (who ? bus_if.ackB : bus_if.ackA) begin
        got = 1'b1;
        tc  = bus_if.tcHit;
      end
      if (who ? bus_if.ackA : bus_if.ackB) other = 1'b1;
    end
    @(posedge clk);
    #1;
    if (who) bus_if.reqB = 1'b0; else bus_if.reqA = 1'b0;
    cnt = cnt_model;
    d00 = s00_cnt - s00_0;
    d10 = s10_cnt - s10_0;
  endtask

  task automatic run_chk(input string tag, input logic who, input logic [1:0] op,
                         input logic [3:0] len, input logic sat, input logic [15:0] data,
                         input logic [15:0] exp_cnt, input logic exp_tc, input int exp_lat);
    logic [15:0] cnt;
    logic tc;
    logic other;
    int lat;
    int d00;
    int d10;
    do_op(who, op, len, sat, data, cnt, tc, lat, d00, d10, other);
    chk({tag, "_cnt"}, 32'(cnt), 32'(exp_cnt));
    chk({tag, "_tc"}, 32'(tc), 32'(exp_tc));
    chk({tag, "_lat"}, lat, exp_lat);
    chk({tag, "_s00"}, d00, (op == 2'b00) ? 1 : 0);
    chk({tag, "_s10"}, d10, (op == 2'b10) ? 1 : 0);
    chk({tag, "_other_ack"}, 32'(other), 32'd0);
  endtask

  task automatic wait_any_ack(output int who, output int at, output logic both);
    int n;
    n = 0; who = -1; both = 1'b0; at = 0;
    while (who < 0 && n < 50) begin
      @(negedge clk);
      n++;
      if (bus_if.ackA && bus_if.ackB) both = 1'b1;
      if (bus_if.ackA) who = 0;
      else if (bus_if.ackB) who = 1;
    end
    at = cyc;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cntS"}, 32'(bus_if.cntS), 32'h3);
    chk({tag, "_enpN"}, 32'(bus_if.cntEnpN), 32'h1);
    chk({tag, "_entN"}, 32'(bus_if.cntEntN), 32'h1);
    chk({tag, "_cntD"}, 32'(bus_if.cntD), 32'h0);
    chk({tag, "_ackA"}, 32'(bus_if.ackA), 32'h0);
    chk({tag, "_ackB"}, 32'(bus_if.ackB), 32'h0);
    chk({tag, "_tcHit"}, 32'(bus_if.tcHit), 32'h0);
    chk({tag, "_busy"}, 32'(bus_if.busy), 32'h0);
  endtask

  vec_t tbl[13];

  initial begin
    int w1, w2, w3, t1, t2, t3, lat;
    logic ov1, ov2, ov3, tc, other;
    logic [15:0] cnt_ref, fin, cnt;
    logic [1:0] op;
    logic [3:0] len;
    logic sat, who, ackseen;
    logic [15:0] data;
    int d00, d10;

    tbl[0]  = '{1'b0, 2'b10, 4'd0,  1'b0, 16'h00FE, 16'h00FE, 1'b0, 2};
    tbl[1]  = '{1'b0, 2'b11, 4'd3,  1'b0, 16'h0000, 16'h0102, 1'b0, 5};
    tbl[2]  = '{1'b1, 2'b10, 4'd0,  1'b0, 16'hFFFE, 16'hFFFE, 1'b0, 2};
    tbl[3]  = '{1'b1, 2'b11, 4'd3,  1'b1, 16'h0000, 16'hFFFF, 1'b1, 3};
    tbl[4]  = '{1'b1, 2'b10, 4'd0,  1'b0, 16'hFFFE, 16'hFFFE, 1'b0, 2};
    tbl[5]  = '{1'b1, 2'b11, 4'd3,  1'b0, 16'h0000, 16'h0002, 1'b1, 5};
    tbl[6]  = '{1'b0, 2'b10, 4'd0,  1'b0, 16'h1234, 16'h1234, 1'b0, 2};
    tbl[7]  = '{1'b1, 2'b01, 4'd4,  1'b0, 16'h0000, 16'h122F, 1'b0, 6};
    tbl[8]  = '{1'b0, 2'b00, 4'd7,  1'b0, 16'hABCD, 16'h0000, 1'b0, 2};
    tbl[9]  = '{1'b0, 2'b01, 4'd1,  1'b1, 16'h0000, 16'h0000, 1'b1, 2};
    tbl[10] = '{1'b1, 2'b01, 4'd1,  1'b0, 16'h0000, 16'hFFFE, 1'b1, 3};
    tbl[11] = '{1'b0, 2'b10, 4'd0,  1'b0, 16'hFFF0, 16'hFFF0, 1'b0, 2};
    tbl[12] = '{1'b1, 2'b11, 4'd15, 1'b0, 16'h0000, 16'h0000, 1'b1, 17};

    bus_if.reqA = 1'b0; bus_if.reqB = 1'b0;
    bus_if.opA = 2'b11; bus_if.opB = 2'b11;
    bus_if.lenA = '0; bus_if.lenB = '0;
    bus_if.satA = 1'b0; bus_if.satB = 1'b0;
    bus_if.dataA = 16'h0; bus_if.dataB = 16'h0;
    asyncResetN = 1'b0;
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    asyncResetN = 1'b1;

    // Simultaneous requests after reset: A, then B, then A again.
    @(negedge clk);
    bus_if.opA = 2'b11; bus_if.lenA = 4'd1; bus_if.satA = 1'b0;
    bus_if.opB = 2'b01; bus_if.lenB = 4'd0; bus_if.satB = 1'b0;
    bus_if.reqA = 1'b1; bus_if.reqB = 1'b1;
    wait_any_ack(w1, t1, ov1);
    @(posedge clk); #1 bus_if.reqA = 1'b0;
    @(negedge clk); bus_if.reqA = 1'b1;
    wait_any_ack(w2, t2, ov2);
    @(posedge clk); #1 bus_if.reqB = 1'b0;
    wait_any_ack(w3, t3, ov3);
    @(posedge clk); #1 bus_if.reqA = 1'b0;
    chk("rr_first", w1, 0);
    chk("rr_second", w2, 1);
    chk("rr_third", w3, 0);
    chk("rr_overlap", 32'(ov1 | ov2 | ov3), 32'd0);
    chk("rr_gap12", 32'((t2 - t1) >= 3), 32'd1);
    chk("rr_gap23", 32'((t3 - t2) >= 3), 32'd1);

    for (int i = 0; i < 13; i++)
      run_chk($sformatf("vec%0d", i), tbl[i].who, tbl[i].op, tbl[i].len, tbl[i].sat,
              tbl[i].data, tbl[i].exp_cnt, tbl[i].exp_tc, tbl[i].exp_lat);

    run_chk("rnd_clr", 1'b0, 2'b00, 4'd0, 1'b0, 16'h0, 16'h0000, 1'b0, 2);
    cnt_ref = 16'h0000;
    for (int n = 0; n < 60; n++) begin
      who = 1'(($urandom_range(0, 1)));
      op  = 2'($urandom_range(0, 3));
      len = 4'($urandom_range(0, 15));
      sat = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 2))
        0: data = 16'($urandom);
        1: data = 16'hFFFF - 16'($urandom_range(0, 8));
        default: data = 16'($urandom_range(0, 8));
      endcase
      ref_model(op, len, sat, data, cnt_ref, fin, tc, lat);
      run_chk($sformatf("rnd%0d", n), who, op, len, sat, data, fin, tc, lat);
      cnt_ref = fin;
    end

    // Reset in the middle of a 16-step increment, after 5 steps.
    run_chk("abort_load", 1'b0, 2'b10, 4'd0, 1'b0, 16'h0100, 16'h0100, 1'b0, 2);
    @(negedge clk);
    bus_if.opA = 2'b11; bus_if.lenA = 4'd15; bus_if.satA = 1'b0; bus_if.reqA = 1'b1;
    @(posedge clk);
    repeat (5) @(posedge clk);
    #2 asyncResetN = 1'b0;
    #1;
    chk_reset_vals("abort");
    chk("abort_cnt", 32'(cnt_model), 32'h0105);
    @(negedge clk);
    bus_if.reqA = 1'b0;
    repeat (2) @(negedge clk);
    asyncResetN = 1'b1;
    ackseen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (bus_if.ackA || bus_if.ackB) ackseen = 1'b1;
    end
    chk("abort_noack", 32'(ackseen), 32'd0);
    chk("abort_cnt_kept", 32'(cnt_model), 32'h0105);

    // First grant after the abort-reset favours A again.
    do_op(1'b0, 2'b11, 4'd0, 1'b0, 16'h0, cnt, tc, lat, d00, d10, other);
    chk("post_abort_cnt", 32'(cnt), 32'h0106);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end
endmodule

// File: doc/counter_seq_ctrl.md
# counter_seq_ctrl

Arbitrating sequencer for a 16-bit counter built from two cascaded 74x867 stages.
- Low stage `entN` is driven by this block; low stage `rcoN` drives high stage `entN`; high stage `rcoN` returns to this block.
- Two requesters share the counter through a req/ack handshake. The block grants one at a time, round-robin, and issues clear, load, increment/decrement bursts, or saturating bursts on the shared S/enable/data pins.
- Used for stack-pointer / address-counter sharing between CPU and DMA in the emulator.

## Interface
- `LEN_W`, default 4: burst length field width. A burst performs len+1 counting steps.
- `clk`  in  1  system clock; same clock as both counter stages.
- `asyncResetN`  in  1  reset, asynchronous, active-low.
- `reqA`, `reqB`  in  1 each  request, level; held stable with its fields until ack.
- `opA`, `opB`  in  2 each  command: 00 clear, 01 decrement, 10 load, 11 increment. Encoding equals counter S.
- `lenA`, `lenB`  in  LEN_W each  burst length minus one; ignored for clear/load.
- `satA`, `satB`  in  1 each  saturate: stop at terminal count instead of wrapping.
- `dataA`, `dataB`  in  16 each  load value.
- `ackA`, `ackB`  out  1 each  one-cycle completion pulse.
- `tcHit`  out  1  valid with ack: terminal count was reached during the op.
- `busy`  out  1  high in RUN and DONE.
- `cntS`  out  2  S[1:0] to both stages.
- `cntEnpN`  out  1  enpN to both stages.
- `cntEntN`  out  1  entN to low stage.
- `cntD`  out  16  parallel load data; [7:0] goes to the low stage.
- `cntRcoN`  in  1  high-stage rcoN (full 16-bit terminal count).

## Operation
- States: IDLE, RUN, DONE.
- IDLE drives hold: `cntS`=11, `cntEnpN`=1, `cntEntN`=1.
  - Never drive S=00 outside a clear op: it asynchronously clears the counter.
  - Never drive S=10 outside a load op: load ignores enables.
- IDLE arbitration, on any request:
  - Only one request: grant it.
  - Both requests: grant the one not granted last. After reset, A wins.
  - On grant, latch op, len, sat and data into internal registers, load the step counter with len (0 for clear/load), go RUN.
- RUN:
  - Registered outputs: `cntS`=op, `cntD`=latched data.
  - `cntEntN`=0 for inc/dec, 1 for clear/load.
  - Registered `enp_r`=0 for inc/dec.
  - `cntEnpN` = `enp_r` | (sat & ~`cntRcoN`). This gating is combinational. `cntRcoN` depends only on registered S/entN, so there is no loop.
  - Clear and load: one RUN cycle, then DONE.
  - Inc/dec, each RUN cycle:
    - If `cntRcoN`=0, set sticky `tc` flag.
    - If sat & `cntRcoN`=0: the step is suppressed by the gating; go DONE.
    - Else if the step counter = 0: go DONE.
    - Else decrement the step counter.
  - Non-saturating bursts wrap (FFFF→0000 up, 0000→FFFF down) and set `tc`.
- DONE:
  - Outputs return to hold.
  - Pulse the granted ack for one cycle; `tcHit`=`tc` (0 for clear/load).
  - Update the round-robin pointer; clear `tc`; go IDLE.
- The requester drops req in the cycle after ack. IDLE therefore never sees a stale request.
- A req asserted during RUN/DONE waits; it is never lost.

## Timing
- Req sampled in IDLE at edge k. Pins change after edge k. The counter acts at edges k+1 … k+len+1.
- Ack latency from the request cycle: len+2 cycles for inc/dec; 2 cycles for clear/load.
- Saturated early stop: DONE follows the RUN cycle in which `cntRcoN` was first seen low.
- Clear: S=00 for exactly one cycle. The counter clears asynchronously during that cycle.
- Back-to-back grants: minimum one IDLE cycle between ack and next RUN.
- Reset values:
  - State IDLE; `cntS`=11; `cntEnpN`=1; `cntEntN`=1; `cntD`=0.
  - `ackA`=`ackB`=0; `tcHit`=0; `busy`=0; round-robin favours A.
- Reset does not disturb the counter value.
- Reset mid-RUN aborts the op with no ack. The counter keeps its partial result.

## Test plan
- Counter=0x00FE; A: inc, len=3, sat=0 → counter 0x0102 (carry across stages); `ackA` 5 cycles after req; `tcHit`=0.
- Counter=0xFFFE; B: inc, len=3, sat=1 → counter stops at 0xFFFF; ack after 2 RUN cycles; `tcHit`=1. Same with sat=0 → counter 0x0002; `tcHit`=1.
- A: load 0x1234, then B: dec len=0x4 → counter 0x122F. Then A: clear → S=00 seen exactly one cycle; counter 0x0000.
- reqA and reqB asserted together, held, each dropped after its ack → grants in order A, B, A. `ack` pulses never overlap, and at least one IDLE cycle separates them.
- Assert `asyncResetN` low mid-burst (inc len=15, after 5 steps) → all outputs at reset values immediately; counter retains 5 increments; no ack.
- Throughout all scenarios: S=00 appears only during clear RUN cycles, and S=10 only during load RUN cycles.
